// File: rtl/fir_pkg.sv
// Shared constants, state encoding and data types for the FIR tap sequencer.
package fir_pkg;

  localparam int TAPS   = 64;
  localparam int IDX_W  = 6;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_seq_state_t;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Sign-extend a full-precision product to accumulator width.
  function automatic acc_t sext_prod(input prod_t p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate unit: acc <= acc + sample*coef at full precision.
module fir_mac
  import fir_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample,
  input  logic [COEF_W-1:0] coef,
  output logic [ACC_W-1:0]  acc
);

  prod_t product;
  acc_t  acc_reg;

  assign product = sample_t'(sample) * coef_t'(coef);
  assign acc     = acc_reg;

  // Accumulator: clear has priority so a new sample always starts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= acc_reg + sext_prod(product);
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR control engine: accepts a sample, shifts it into the external delay
// line, walks every tap through the MAC, then offers the result downstream.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] rf_in_data,
  output logic              rf_reg_write,
  output logic [IDX_W-1:0]  rf_rd_reg,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [IDX_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy
);

  fir_seq_state_t   state_reg;
  fir_seq_state_t   state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] hold_reg;
  logic             accept;
  logic             mac_en;
  logic             last_tap;

  assign last_tap  = (idx_reg == IDX_W'(TAPS-1));
  assign rf_rd_reg = idx_reg;
  assign coef_addr = idx_reg;

  // While offering a result the live accumulator is shown; otherwise the
  // last delivered result is held so out_data never shows partial sums.
  assign out_data = out_valid ? acc : hold_reg;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs; none depend on rf_rd_data.
  always_comb begin
    state_next   = state_reg;
    in_ready     = 1'b0;
    rf_reg_write = 1'b0;
    rf_in_data   = '0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    accept       = 1'b0;
    mac_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept       = 1'b1;
          rf_reg_write = 1'b1;
          rf_in_data   = in_data;
          state_next   = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_tap) begin
          state_next = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tap index: restarts on each accepted sample, wraps naturally after TAPS-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_reg <= '0;
    end else if (accept) begin
      idx_reg <= '0;
    end else if (mac_en) begin
      idx_reg <= idx_reg + 1'b1;
    end
  end

  // Capture the delivered result so it stays visible after the handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_reg <= '0;
    end else if (out_valid && out_ready) begin
      hold_reg <= acc;
    end
  end

  fir_mac u_mac (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (mac_en),
    .sample (rf_rd_data),
    .coef   (coef_data),
    .acc    (acc)
  );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer with a behavioural delay line,
// coefficient ROM and a dot-product reference model over sample history.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] rf_in_data;
  logic              rf_reg_write;
  logic [IDX_W-1:0]  rf_rd_reg;
  logic [DATA_W-1:0] rf_rd_data;
  logic [IDX_W-1:0]  coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] dl [TAPS];
  logic [COEF_W-1:0] coef_mem [TAPS];
  longint            hist_q [$];

  always #5 clock = ~clock;

  fir_tap_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .rf_in_data   (rf_in_data),
    .rf_reg_write (rf_reg_write),
    .rf_rd_reg    (rf_rd_reg),
    .rf_rd_data   (rf_rd_data),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  // Environment: external delay line (cleared by the shared reset) and ROM.
  assign rf_rd_data = dl[rf_rd_reg];
  assign coef_data  = coef_mem[coef_addr];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) dl[i] <= '0;
    end else if (rf_reg_write) begin
      for (int i = TAPS-1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= rf_in_data;
    end
  end

  // Reference model: y = sum over history of sample[k]*coef[k], newest first.
  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < hist_q.size(); k++)
      s += hist_q[k] * longint'($signed(coef_mem[k]));
    return s;
  endfunction

  function automatic logic [ACC_W-1:0] model_bits();
    longint m;
    m = model_out();
    return m[ACC_W-1:0];
  endfunction

  task automatic model_shift(input logic [DATA_W-1:0] d);
    hist_q.push_front(longint'($signed(d)));
    if (hist_q.size() > TAPS) void'(hist_q.pop_back());
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    hist_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Offer one sample (called at a negedge); returns at the negedge after acceptance.
  task automatic push(input logic [DATA_W-1:0] d, output bit ok);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    ok = in_ready;
    if (ok) model_shift(d);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Wait for a result with out_ready high; lat counts negedges waited.
  task automatic get_result(output logic [ACC_W-1:0] data, output int lat);
    lat = 0;
    out_ready = 1'b1;
    while (!out_valid && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    data = out_data;
    $display("[%0t] result %0d latency %0d", $time, $signed(data), lat);
    @(negedge clock);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 16'h5a5a; out_ready = 1'b1; reset = 1'b0;
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (rf_reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_rf_reg_write: got %b want 0", rf_reg_write); end
    n_cmp++; if (rf_in_data !== '0) begin n_bad++; $display("FAIL reset_rf_in_data: got %h want 0", rf_in_data); end
    n_cmp++; if (rf_rd_reg !== '0 || coef_addr !== '0) begin n_bad++; $display("FAIL reset_index: got %0d/%0d want 0/0", rf_rd_reg, coef_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    hist_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_strobe();
    logic [DATA_W-1:0] d;
    logic [ACC_W-1:0]  r;
    int lat;
    for (int k = 0; k < TAPS; k++) coef_mem[k] = DATA_W'($urandom);
    d = DATA_W'($urandom);
    in_data = d; in_valid = 1'b1;
    #1;
    n_cmp++; if (rf_reg_write !== 1'b1 || rf_in_data !== d) begin n_bad++; $display("FAIL strobe_write: got %b/%h want 1/%h", rf_reg_write, rf_in_data, d); end
    model_shift(d);
    @(negedge clock);
    n_cmp++; if (rf_reg_write !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL strobe_mac: got wr=%b rdy=%b busy=%b want 0/0/1", rf_reg_write, in_ready, busy); end
    in_valid = 1'b0;
    get_result(r, lat);
    n_cmp++; if (lat !== TAPS) begin n_bad++; $display("FAIL strobe_latency: got %0d want %0d", lat, TAPS); end
    n_cmp++; if (r !== model_bits()) begin n_bad++; $display("FAIL strobe_data: got %0d want %0d", $signed(r), model_out()); end
  endtask

  task automatic test_impulse();
    logic [DATA_W-1:0] samples [4];
    logic [ACC_W-1:0]  r;
    int lat;
    bit ok;
    samples = '{16'd1, 16'd0, 16'd0, 16'd0};
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = COEF_W'(k + 1);
    for (int i = 0; i < 4; i++) begin
      push(samples[i], ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL impulse_accept: got timeout want handshake"); end
      get_result(r, lat);
      n_cmp++; if (lat !== TAPS) begin n_bad++; $display("FAIL impulse_latency: got %0d want %0d", lat, TAPS); end
      n_cmp++; if (r !== ACC_W'(i + 1)) begin n_bad++; $display("FAIL impulse_data: got %0d want %0d", $signed(r), i + 1); end
    end
  endtask

  task automatic test_step();
    logic [ACC_W-1:0] r;
    int lat;
    bit ok;
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'd1;
    for (int i = 0; i <= TAPS; i++) begin
      push(16'd100, ok);
      get_result(r, lat);
      n_cmp++; if (!ok || lat !== TAPS) begin n_bad++; $display("FAIL step_latency: got %0d want %0d", lat, TAPS); end
      n_cmp++; if (r !== model_bits()) begin n_bad++; $display("FAIL step_model: got %0d want %0d", $signed(r), model_out()); end
      n_cmp++; if (r !== ACC_W'(100 * ((i < TAPS) ? i + 1 : TAPS))) begin n_bad++; $display("FAIL step_value: sample %0d got %0d", i, $signed(r)); end
    end
  endtask

  task automatic test_corner();
    logic [ACC_W-1:0] r;
    int lat;
    bit ok;
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'h8000;
    for (int i = 0; i < TAPS; i++) begin
      push(16'h8000, ok);
      get_result(r, lat);
      n_cmp++; if (!ok || r !== model_bits()) begin n_bad++; $display("FAIL corner_model: got %0d want %0d", $signed(r), model_out()); end
    end
    n_cmp++; if (r !== 38'd68719476736) begin n_bad++; $display("FAIL corner_final: got %0d want 68719476736", $signed(r)); end
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] r, held;
    logic [DATA_W-1:0] pend;
    int lat;
    bit ok;
    for (int k = 0; k < TAPS; k++) coef_mem[k] = COEF_W'($urandom);
    out_ready = 1'b0;
    push(DATA_W'($urandom), ok);
    lat = 0;
    while (!out_valid && lat < 300) begin @(negedge clock); lat++; end
    n_cmp++; if (!ok || lat !== TAPS) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", lat, TAPS); end
    held = out_data;
    n_cmp++; if (held !== model_bits()) begin n_bad++; $display("FAIL bp_data: got %0d want %0d", $signed(held), model_out()); end
    pend = DATA_W'($urandom);
    in_data = pend; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin n_bad++; $display("FAIL bp_hold: cycle %0d got v=%b d=%0d want 1/%0d", i, out_valid, $signed(out_data), $signed(held)); end
      n_cmp++; if (in_ready !== 1'b0 || rf_reg_write !== 1'b0) begin n_bad++; $display("FAIL bp_block: cycle %0d got rdy=%b wr=%b want 0/0", i, in_ready, rf_reg_write); end
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== held) begin n_bad++; $display("FAIL bp_release: got v=%b rdy=%b d=%0d want 0/1/%0d", out_valid, in_ready, $signed(out_data), $signed(held)); end
    // The held sample is taken only now.
    model_shift(pend);
    @(negedge clock);
    in_valid = 1'b0;
    get_result(r, lat);
    n_cmp++; if (lat !== TAPS || r !== model_bits()) begin n_bad++; $display("FAIL bp_followup: got %0d lat %0d want %0d", $signed(r), lat, model_out()); end
  endtask

  task automatic test_reset_mid_mac();
    logic [ACC_W-1:0] r;
    int lat, seen;
    bit ok;
    for (int k = 0; k < TAPS; k++) coef_mem[k] = COEF_W'(k + 1);
    push(DATA_W'($urandom_range(1, 1000)), ok);
    repeat (19) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_ctrl: got busy=%b rdy=%b v=%b want 0/1/0", busy, in_ready, out_valid); end
    n_cmp++; if (rf_rd_reg !== '0 || coef_addr !== '0 || rf_reg_write !== 1'b0 || out_data !== '0) begin n_bad++; $display("FAIL midrst_data: got rd=%0d ca=%0d wr=%b d=%0d want 0", rf_rd_reg, coef_addr, rf_reg_write, $signed(out_data)); end
    hist_q.delete();
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < TAPS + 10; i++) begin
      if (out_valid) seen++;
      @(negedge clock);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_output: got %0d outputs want 0", seen); end
    push(16'd1, ok);
    get_result(r, lat);
    n_cmp++; if (!ok || r !== ACC_W'(1)) begin n_bad++; $display("FAIL midrst_impulse: got %0d want 1", $signed(r)); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] s [5];
    logic [ACC_W-1:0]  exp_q [$];
    logic [ACC_W-1:0]  e;
    int acc_cnt, out_cnt, last_acc, cyc, extra;
    for (int k = 0; k < TAPS; k++) coef_mem[k] = COEF_W'($urandom);
    for (int i = 0; i < 5; i++) s[i] = DATA_W'($urandom);
    acc_cnt = 0; out_cnt = 0; last_acc = 0; cyc = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = s[0];
    while (out_cnt < 5 && cyc < 5 * (TAPS + 2) + 50) begin
      if (in_valid && in_ready) begin
        if (acc_cnt > 0) begin
          n_cmp++; if (cyc - last_acc !== TAPS + 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_acc, TAPS + 2); end
        end
        last_acc = cyc;
        model_shift(in_data);
        exp_q.push_back(model_bits());
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        $display("[%0t] b2b result %0d", $time, $signed(out_data));
        n_cmp++; if (out_data !== e) begin n_bad++; $display("FAIL b2b_data: got %0d want %0d", $signed(out_data), $signed(e)); end
        out_cnt++;
      end
      @(negedge clock);
      cyc++;
      if (acc_cnt < 5) in_data = s[acc_cnt];
      else in_valid = 1'b0;
    end
    extra = 0;
    for (int i = 0; i < TAPS + 4; i++) begin
      if (out_valid) extra++;
      @(negedge clock);
    end
    n_cmp++; if (out_cnt !== 5 || acc_cnt !== 5 || extra !== 0) begin n_bad++; $display("FAIL b2b_count: got out=%0d acc=%0d extra=%0d want 5/5/0", out_cnt, acc_cnt, extra); end
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] r;
    int lat, stall;
    bit ok;
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = COEF_W'($urandom);
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b0;
      push(DATA_W'($urandom), ok);
      lat = 0;
      while (!out_valid && lat < 300) begin @(negedge clock); lat++; end
      n_cmp++; if (!ok || lat !== TAPS) begin n_bad++; $display("FAIL rand_latency: got %0d want %0d", lat, TAPS); end
      stall = $urandom_range(0, 4);
      repeat (stall) @(negedge clock);
      r = out_data;
      $display("[%0t] random result %0d stall %0d", $time, $signed(r), stall);
      n_cmp++; if (out_valid !== 1'b1 || r !== model_bits()) begin n_bad++; $display("FAIL rand_data: got %0d want %0d", $signed(r), model_out()); end
      out_ready = 1'b1;
      @(negedge clock);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    reset = 1'b0;
    for (int k = 0; k < TAPS; k++) coef_mem[k] = '0;
    test_reset();
    test_strobe();
    test_impulse();
    test_step();
    test_corner();
    test_backpressure();
    test_reset_mid_mac();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
